// File: rtl/serializer_pkg.sv
// Shared types and width helpers for the bit stream serializer.
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Width of load_len and bit_count: must hold the value WIDTH itself.
   function automatic int len_width(input int width);
      return $clog2(width) + 1;
   endfunction

   // The gap counter only ever holds GAP_CYCLES-1.
   function automatic int gap_width(input int gap_cycles);
      return (gap_cycles < 2) ? 1 : $clog2(gap_cycles);
   endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with terminal-count flag; load wins over decrement, holds at zero.
// Latency: count updates on the edge after load/en; tc is combinational from the count.
module bit_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel frame in via valid/ready (ready only in IDLE), serial out one bit per clock.
// First bit is registered on x_out the cycle after the load edge; optional replay with idle gap.
module bit_stream_serializer
   import serializer_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0,
   parameter int   GAP_CYCLES = 1,
   localparam int  LW         = len_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LW-1:0]    load_len,
   input  logic             repeat_en,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic [LW-1:0]    bit_count
);

   localparam int            GW       = gap_width(GAP_CYCLES);
   localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t           state, state_n;
   logic [WIDTH-1:0] frame_q, src_frame;
   logic [LW-1:0]    len_q, eff_len, src_len;
   logic             bit_tc, gap_tc;
   logic             load_fire, advance, last_bit, replay_now, gap_done, start;
   logic             first_bit, next_bit;

   // Bit idx (0 = first sent) of a frame of length len, in the configured order.
   function automatic logic pick_bit(input logic [WIDTH-1:0] f,
                                     input logic [LW-1:0]    len,
                                     input logic [LW-1:0]    idx);
      logic [WIDTH-1:0] sh;
      logic [LW-1:0]    pos;
      pos = LSB_FIRST ? idx : (len - idx - LW'(1));
      sh  = f >> pos;
      return sh[0];
   endfunction

   assign eff_len    = ((load_len == '0) || (load_len > FULL_LEN)) ? FULL_LEN : load_len;
   assign load_fire  = (state == IDLE) && load_valid;
   assign advance    = (state == SHIFT) && !bit_tc;
   assign last_bit   = (state == SHIFT) && bit_tc;
   assign replay_now = last_bit && repeat_en && (GAP_CYCLES == 0);
   assign gap_done   = (state == GAP) && gap_tc;
   assign start      = load_fire || replay_now || gap_done;

   // A new frame starts either from the load inputs or from the stored copy.
   assign src_frame  = load_fire ? load_data : frame_q;
   assign src_len    = load_fire ? eff_len : len_q;
   assign first_bit  = pick_bit(src_frame, src_len, '0);
   assign next_bit   = pick_bit(frame_q, len_q, bit_count + LW'(1));

   bit_down_counter #(.W(LW)) u_bit_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (start),
      .load_val (src_len - LW'(1)),
      .en       (advance),
      .tc       (bit_tc)
   );

   bit_down_counter #(.W(GW)) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (last_bit && repeat_en),
      .load_val (GAP_LOAD),
      .en       (state == GAP),
      .tc       (gap_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (load_valid) state_n = SHIFT;
         SHIFT: begin
            if (bit_tc) begin
               if (!repeat_en)          state_n = IDLE;
               else if (GAP_CYCLES > 0) state_n = GAP;
               else                     state_n = SHIFT;
            end
         end
         GAP:     if (gap_tc) state_n = SHIFT;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q   <= '0;
         len_q     <= '0;
         x_out     <= IDLE_LEVEL;
         x_valid   <= 1'b0;
         done      <= 1'b0;
         bit_count <= '0;
      end else begin
         if (load_fire) begin
            frame_q <= load_data;
            len_q   <= eff_len;
         end
         done    <= last_bit;
         x_valid <= start || advance;
         if (start)        x_out <= first_bit;
         else if (advance) x_out <= next_bit;
         else              x_out <= IDLE_LEVEL;
         bit_count <= advance ? (bit_count + LW'(1)) : '0;
      end
   end

   assign busy       = (state != IDLE);
   assign load_ready = (state == IDLE);

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
Upstream stimulus stage for the 2-bit Mealy sequence FSM. It accepts a parallel frame through a valid/ready handshake and shifts it out one bit per clock on x_out, which drives the FSM's serial input x. Frame length is programmable. An optional repeat mode replays the stored frame with a programmable idle gap between frames, so the FSM can be exercised continuously without testbench-driven bit sequences.

Parameters:
WIDTH, 8, maximum frame length in bits (must be at least 2)
LSB_FIRST, 0, 0 = shift MSB of the active frame first; 1 = shift bit 0 first
IDLE_LEVEL, 0, value driven on x_out whenever no frame bit is being sent
GAP_CYCLES, 1, number of idle cycles between repeated frames (0 allowed)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
load_valid  input  1  frame offered on load_data/load_len
load_ready  output  1  serializer can accept a frame; high only in IDLE
load_data  input  WIDTH  frame bits; the active frame is load_data[len-1:0]
load_len  input  LW = clog2(WIDTH)+1  number of bits to send
repeat_en  input  1  replay the stored frame after the gap instead of returning to IDLE
x_out  output  1  registered serial bit to the downstream FSM input x
x_valid  output  1  high while x_out carries a frame bit
busy  output  1  high in SHIFT or GAP
done  output  1  one-cycle pulse after the last bit of each frame
bit_count  output  LW  bits already sent in the current frame

Behaviour:
- Reset: the state machine enters IDLE. Outputs are x_out=IDLE_LEVEL, x_valid=0, busy=0, done=0, bit_count=0, load_ready=1. The shift register and stored length clear to 0.
- Reset asserted mid-frame aborts the frame immediately. done does not pulse and the stored frame is lost.
- States:
  - IDLE -> SHIFT when load_valid && load_ready.
  - SHIFT -> GAP at the end of the frame when repeat_en=1 and GAP_CYCLES>0.
  - SHIFT -> SHIFT (replay) at the end of the frame when repeat_en=1 and GAP_CYCLES=0.
  - SHIFT -> IDLE at the end of the frame when repeat_en=0.
  - GAP -> SHIFT after GAP_CYCLES cycles.
- Load handshake: the transfer occurs on edge k where load_valid && load_ready.
  - load_data and the effective length L are stored on that edge.
  - L = WIDTH when load_len=0 or load_len>WIDTH; otherwise L = load_len.
  - Load offers made outside IDLE are ignored; load_ready is 0 there.
- Latency: the first bit appears on x_out with x_valid=1 in the cycle after edge k. Each bit is held for exactly one cycle.
- Bit order:
  - MSB-first sends bit L-1 first.
  - LSB-first sends bit 0 first.
- bit_count is 0 during the first bit and increments each cycle up to L-1.
- End of frame: on the edge ending bit L-1, done goes high for one cycle and bit_count returns to 0.
  - x_out returns to IDLE_LEVEL and x_valid=0, unless a GAP_CYCLES=0 replay starts. In that case the first bit of the next frame appears in the same cycle as done.
- repeat_en is sampled only on the edge ending the last bit. Changing it mid-frame has no effect until the frame ends.
  - Deasserting repeat_en during GAP: the pending replay still runs once. The block returns to IDLE after that frame.
- During GAP: x_out=IDLE_LEVEL, x_valid=0, busy=1, load_ready=0.
- busy = (state != IDLE). load_ready = (state == IDLE).
- All outputs except load_ready and busy are registered directly; no combinational path from inputs to x_out.

Decomposition:
- Shared package serializer_pkg holds:
  - the state enum {IDLE, SHIFT, GAP} as a 2-bit encoding;
  - the LW width function or constant;
  - the gap counter width.
- One natural sub-module, bit_down_counter: a loadable down counter with a terminal-count flag, used for both the remaining-bit count and the gap count.
- Shift logic and the FSM stay in the top module.

Test Plan:
- Reset hold, then release: for 40 ns with rst=1 -> x_out=0, x_valid=0, busy=0, done=0, load_ready=1; rst=0 with load_valid=0 for 3 cycles -> all outputs unchanged.
- Frame load_data=8'b0111_0100, load_len=8, MSB-first, repeat_en=0 -> x_out sequence 0,1,1,1,0,1,0,0 on 8 consecutive cycles; done pulses 1 cycle later; load_ready returns to 1.
- load_len=3, load_data=8'bxxxx_x110, LSB_FIRST=1 -> x_out 0,1,1; bit_count 0,1,2; done after 3 bits. load_len=0 -> 8 bits sent.
- repeat_en=1, GAP_CYCLES=2, frame 3'b101 -> 1,0,1, then idle, idle, then 1,0,1, and so on; done pulses each frame. Drop repeat_en in the second frame -> IDLE after it.
- GAP_CYCLES=0 with repeat -> continuous 1,0,1,1,0,1; done coincides with each replayed first bit.
- rst asserted at the 4th bit -> x_out=IDLE_LEVEL and busy=0 immediately, no done; a load_valid offered during SHIFT is ignored and not stored.
